alu_req_arbiter: RTL
====================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset is synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_opcode  input  6  MIPS opcode field of requester 0.
REQ-007 req0_funct  input  6  MIPS funct field of requester 0.
REQ-008 req0_A, req0_B  input  DATA_W each  operands of requester 0.
REQ-009 req1_valid, req1_ready, req1_opcode, req1_funct, req1_A, req1_B  same directions, widths and meanings as REQ-004..REQ-008, for requester 1.
REQ-010 alu_opcode, alu_funct  output  6 each  to shared ALUdec.
REQ-011 alu_A, alu_B  output  DATA_W each  to shared ALU.
REQ-012 alu_out  input  DATA_W  combinational result from shared ALU.
REQ-013 rsp_valid  output  1  response register holds a result.
REQ-014 rsp_ready  input  1  consumer takes the response this cycle.
REQ-015 rsp_id  output  1  requester that issued the held result.
REQ-016 rsp_result  output  DATA_W  held result.

Function
REQ-017 The block SHALL share one combinational ALUdec+ALU between two requesters, one operation accepted per cycle at most.
REQ-018 slot_free SHALL be (!rsp_valid || rsp_ready); no request is accepted when slot_free is 0.
REQ-019 Grant: only one valid -> that one; both valid -> requester not granted most recently (last_grant register); neither -> no grant.
REQ-020 reqN_ready SHALL be high iff reqN is granted and slot_free (combinational); ready SHALL never be high with valid low.
REQ-021 In the accept cycle alu_* SHALL carry the granted requester's opcode, funct, A, B; with no grant alu_* SHALL be all zeros.
REQ-022 On an accept edge: rsp_result <= alu_out, rsp_id <= granted index, rsp_valid <= 1, last_grant <= granted index; latency is exactly 1 cycle from accept to rsp_valid.
REQ-023 rsp_valid && rsp_ready with no new accept SHALL clear rsp_valid at the edge; with a simultaneous accept the register is overwritten and rsp_valid stays 1 (full throughput).
REQ-024 While rsp_valid && !rsp_ready, rsp_id and rsp_result SHALL hold stable and both reqN_ready SHALL be 0.
REQ-025 Requesters SHALL hold all reqN_* fields stable while valid and not ready; the block SHALL not capture operands except on accept.
REQ-026 Arithmetic is entirely the ALU's; the block SHALL pass fields and results unmodified at full DATA_W (no truncation, no sign handling).
REQ-027 Under continuous dual requests with rsp_ready=1, grants SHALL strictly alternate; no requester waits more than one accept.

Reset
REQ-028 Reset high at an edge SHALL set rsp_valid=0, rsp_id=0, rsp_result=0, last_grant=1 (requester 0 wins first tie), overriding any accept in that cycle.
REQ-029 While Reset is high both reqN_ready SHALL be 0 and alu_* SHALL be zero; an in-flight response is discarded.

Verification
REQ-030 Reset, idle inputs -> rsp_valid=0, req0_ready=req1_ready=0, alu_A=alu_B=0.
REQ-031 req0 RTYPE/ADDU A=5 B=7, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
REQ-032 Both valid from reset, req0 SUBU A=10 B=3, req1 LW A=0x100 B=0x4 (random funct), rsp_ready=1 -> cycle1 id=0 result=7, cycle2 id=1 result=0x104, then alternation continues.
REQ-033 rsp_valid=1, rsp_ready=0 for 3 cycles with both valid -> readies 0, rsp_result stable; rsp_ready=1 -> same-cycle accept of the non-last requester, rsp_valid stays 1.
REQ-034 Reset asserted one cycle while rsp_valid=1 and req1 valid -> next cycle rsp_valid=0, no accept; then both valid -> requester 0 granted first.
REQ-035 RTYPE/SLT A=0xFFFFFFFD B=0 via req1 -> rsp_id=1, rsp_result=1 (signed compare passed through).

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for one shared combinational ALUdec+ALU.
// Alternating-priority grant with a single registered response slot.
module alu_req_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [5:0]        req0_opcode,
  input  logic [5:0]        req0_funct,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [5:0]        req1_opcode,
  input  logic [5:0]        req1_funct,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  output logic [5:0]        alu_opcode,
  output logic [5:0]        alu_funct,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result
);

  logic last_grant;
  logic grant0;
  logic grant1;
  logic slot_free;
  logic accept;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign slot_free  = !rsp_valid || rsp_ready;
  assign accept     = (grant0 || grant1) && slot_free;
  assign req0_ready = grant0 && slot_free;
  assign req1_ready = grant1 && slot_free;

  always_comb begin
    alu_opcode = '0;
    alu_funct  = '0;
    alu_A      = '0;
    alu_B      = '0;
    if (grant0) begin
      alu_opcode = req0_opcode;
      alu_funct  = req0_funct;
      alu_A      = req0_A;
      alu_B      = req0_B;
    end else if (grant1) begin
      alu_opcode = req1_opcode;
      alu_funct  = req1_funct;
      alu_A      = req1_A;
      alu_B      = req1_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_result <= alu_out;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
